oled_char_buffer: RTL
=====================

// Module: oled_char_buffer
// PURPOSE
//  Responder end of the processor's OLED character-write port (we / write_addr / write_data).
//  Holds a 64-cell ASCII screen image: direct writes to cells 0..62, append-at-cursor via APPEND_ADDR.
//  On request it streams the whole image, cell 0..63, to the OLED renderer over a valid/ready link.
//  Sits between the processor core and display_top's glyph renderer; one per display.
// PARAMETERS
//  DEPTH        64     number of character cells (fixed 2**ADDR_W)
//  ADDR_W       6      cell index width
//  APPEND_ADDR  6'h3F  write_addr value meaning "append at cursor"
//  BLANK        8'h20  fill character used by clear
//  FF_CHAR      8'h0C  write_data value that requests a full clear (form feed)
// PORTS
//  sysclk      in   1  clock, all logic on rising edge
//  cpu_reset   in   1  synchronous reset, active-high
//  we          in   1  character write strobe, one write per cycle
//  write_addr  in   6  cell index 0..62, or APPEND_ADDR
//  write_data  in   8  ASCII code; FF_CHAR = clear request
//  frame_req   in   1  renderer requests a frame (level, sampled in IDLE only)
//  out_valid   out  1  out_data/out_idx hold a valid cell
//  out_ready   in   1  renderer accepts the cell when out_valid && out_ready
//  out_data    out  8  character of cell out_idx
//  out_idx     out  6  cell index being presented
//  out_last    out  1  high with out_valid when out_idx == 63
//  cursor      out  6  next append position
//  dirty       out  1  image changed since last frame start
//  busy        out  1  high in CLEAR or while a clear is pending
//  drop        out  1  one-cycle pulse: a write was discarded
// BEHAVIOUR
//  Reset: state<=CLEAR, clr_idx<=0, cursor<=0, out_valid/out_last/drop<=0, dirty<=1, out_data<=BLANK,
//   out_idx<=0. Reset mid-stream aborts the frame: out_valid is 0 the cycle after reset asserts.
//  FSM: IDLE, CLEAR, STREAM.
//   CLEAR: writes BLANK to cell clr_idx each cycle, clr_idx 0..63 (64 cycles), then IDLE; cursor<=0, dirty<=1.
//    Any we during CLEAR is discarded and pulses drop next cycle.
//   IDLE: if clr_pend -> CLEAR; else if frame_req && dirty -> STREAM; frame_req with dirty=0 is ignored.
//   STREAM entry: out_valid<=1, out_idx<=0, out_data<=mem[0], dirty<=0.
//    On accept: if out_idx==63 -> out_valid<=0, IDLE; else out_idx+1, out_data<=mem[out_idx+1].
//    No accept: out_data/out_idx/out_valid held stable (AXI-style; valid never drops without accept).
//    Throughput: one cell per cycle when out_ready stays high; frame = 64 accepted beats.
//  Writes (IDLE or STREAM):
//   write_addr 0..62, data != FF_CHAR: mem[addr]<=data; cursor unchanged.
//   write_addr == APPEND_ADDR, data != FF_CHAR: mem[cursor]<=data; cursor<=cursor+1, wraps 63->0.
//   data == FF_CHAR (any addr): no cell write; in IDLE -> CLEAR next cycle; in STREAM -> clr_pend<=1,
//    busy<=1, frame completes unchanged, then CLEAR. Further writes while clr_pend still apply.
//   Every applied write sets dirty<=1; set wins over the STREAM-entry clear in the same cycle.
//  Bypass: a write to the cell being loaded into out_data that cycle loads the new write_data.
//   A write to the currently presented (held) cell does not alter out_data; dirty stays 1.
//  frame_req and FF_CHAR write in the same IDLE cycle: CLEAR wins; frame starts after clear.
//  busy = (state==CLEAR) | clr_pend. drop is the only way a write is lost.
// STRUCTURE
//  Shared package oled_pkg: ADDR_W, APPEND_ADDR, BLANK, FF_CHAR, state enum {IDLE,CLEAR,STREAM}.
//  One sub-module: char_ram (64x8, one sync write port, one async read port) -- writes muxed
//   between processor port and clear engine; all FSM/handshake logic stays in this module.
// TESTING
//  1 Reset, hold 70 cycles, frame_req=1, out_ready=1 -> busy high 64 cycles, then 64 beats of 8'h20, out_last on idx 63.
//  2 Append 'H','I' (addr 3F) then write 'Z' to addr 5 -> cursor=2; frame: idx0=8'h48, idx1=8'h49, idx5=8'h5A.
//  3 64 appends of 8'h41+i -> cursor wraps to 0, 65th append overwrites cell 0, dirty=1.
//  4 Stream with out_ready toggling 1,0,0,1...; write FF_CHAR at idx 10 -> 64 stable beats, busy=1,
//    then CLEAR 64 cycles, next frame all 8'h20.
//  5 Write during CLEAR -> drop pulses once, cell unchanged after clear.
//  6 After full frame with no writes, frame_req=1 -> no out_valid; write one cell same cycle as
//    STREAM entry -> dirty remains 1 after frame.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and state encoding for the OLED character buffer.
package oled_pkg;
  localparam int          ADDR_W      = 6;
  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [5:0]  APPEND_ADDR = 6'h3F;
  localparam logic [7:0]  BLANK       = 8'h20;
  localparam logic [7:0]  FF_CHAR     = 8'h0C;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;
endpackage

// File: rtl/char_ram.sv
// 64x8 character store: one synchronous write port, one asynchronous read port.
module char_ram
  import oled_pkg::*;
(
  input  logic              sysclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge sysclk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/oled_char_buffer.sv
// Processor-facing OLED character image with clear engine and valid/ready frame streamer.
module oled_char_buffer
  import oled_pkg::*;
(
  input  logic              sysclk,
  input  logic              cpu_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [7:0]        write_data,
  input  logic              frame_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic [ADDR_W-1:0] cursor,
  output logic              dirty,
  output logic              busy,
  output logic              drop
);
  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_pend;

  logic              cpu_wr, wr_ff, wr_cell, accept;
  logic [ADDR_W-1:0] wr_addr, ld_idx, ram_addr;
  logic [7:0]        rd_data, ld_data, ram_data;
  logic              ram_we;

  assign cpu_wr  = we && (state != CLEAR);
  assign wr_ff   = cpu_wr && (write_data == FF_CHAR);
  assign wr_cell = cpu_wr && (write_data != FF_CHAR);
  assign wr_addr = (write_addr == APPEND_ADDR) ? cursor : write_addr;
  assign accept  = out_valid && out_ready;

  // Cell about to be loaded into out_data; a same-cycle write to it bypasses the RAM.
  assign ld_idx  = (state == IDLE) ? '0 : out_idx + 6'd1;
  assign ld_data = (wr_cell && (wr_addr == ld_idx)) ? write_data : rd_data;

  assign ram_we   = (state == CLEAR) || wr_cell;
  assign ram_addr = (state == CLEAR) ? clr_idx : wr_addr;
  assign ram_data = (state == CLEAR) ? BLANK : write_data;

  assign busy = (state == CLEAR) || clr_pend;

  char_ram u_ram (
    .sysclk (sysclk),
    .we     (ram_we),
    .waddr  (ram_addr),
    .wdata  (ram_data),
    .raddr  (ld_idx),
    .rdata  (rd_data)
  );

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      clr_pend  <= 1'b0;
      cursor    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_data  <= BLANK;
      dirty     <= 1'b1;
      drop      <= 1'b0;
    end else begin
      drop <= we && (state == CLEAR);
      if (wr_cell) begin
        dirty <= 1'b1;
        if (write_addr == APPEND_ADDR) cursor <= cursor + 6'd1;
      end
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 6'd1;
          cursor  <= '0;
          dirty   <= 1'b1;
          if (clr_idx == 6'd63) state <= IDLE;
        end
        IDLE: begin
          if (clr_pend || wr_ff) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            clr_pend <= 1'b0;
          end else if (frame_req && dirty) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_data  <= ld_data;
            if (!wr_cell) dirty <= 1'b0;
          end
        end
        STREAM: begin
          if (wr_ff) clr_pend <= 1'b1;
          if (accept) begin
            if (out_idx == 6'd63) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              out_idx  <= ld_idx;
              out_data <= ld_data;
              out_last <= (ld_idx == 6'd63);
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
